// File: rtl/sseg_pkg.sv
// Shared types and segment helpers for the scanned seven-segment display.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/sseg_scan_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, MSB first.
// i_start loads the operand; o_done is high during the final iteration cycle.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] r_sh;
  logic [BCD_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [BCD_W-1:0] w_adj;

  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
  end

  assign o_done = r_active && (r_cnt == CNT_W'(BIN_W - 1));
  assign o_bcd  = r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_sh     <= i_bin;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_acc <= {w_adj[BCD_W-2:0], r_sh[BIN_W-1]};
      r_sh  <= r_sh << 1;
      if (o_done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_display.sv
// Loadable multi-digit display: decimal via bin2bcd_seq or raw hex, one-deep pending load, scanned active-low outputs.
// LEADING_ZERO_BLANK_EN blanks leading zero digits of decimal values.
module sseg_scan_display
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BIN_W-1:0]  BIN_IN,
  input  logic              LOAD,
  input  logic              HEX_MODE,
  output logic              BUSY,
  output logic              OVF,
  output logic [6:0]        sseg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SRC_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  state_t            r_state, w_next;
  logic              r_busy, r_ovf, r_ovf_next, r_mode_hex, r_disp_hex;
  logic              r_pend, r_pend_hex;
  logic [BIN_W-1:0]  r_pend_bin;
  logic [BCD_W-1:0]  r_hexval, r_digits;
  logic [IDX_W-1:0]  r_idx;
  logic [REF_W-1:0]  r_ref;

  logic              w_start, w_start_hex, w_commit, w_done, w_ovf_start;
  logic [BIN_W-1:0]  w_start_bin;
  logic [SRC_W-1:0]  w_start_ext;
  logic [BCD_W-1:0]  w_bcd;
  logic [3:0]        w_digit;
  logic [6:0]        w_seg;
  logic [DIGITS-1:0] w_an;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_bcd (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_start (w_start && !w_start_hex),
    .i_bin   (w_start_bin),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_start_bin = BIN_IN;
    w_start_hex = HEX_MODE;
    case (r_state)
      IDLE: begin
        // A pending entry left by a LOAD during a final COMMIT starts here
        if (LOAD) begin
          w_start = 1'b1;
        end else if (r_pend) begin
          w_start     = 1'b1;
          w_start_bin = r_pend_bin;
          w_start_hex = r_pend_hex;
        end
      end
      SHIFT: if (w_done) w_next = COMMIT;
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
        if (r_pend) begin
          w_start     = 1'b1;
          w_start_bin = r_pend_bin;
          w_start_hex = r_pend_hex;
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_start) w_next = w_start_hex ? COMMIT : SHIFT;
  end

  assign w_start_ext = SRC_W'(w_start_bin);
  assign w_ovf_start = w_start_hex ? ((w_start_ext >> BCD_W) != '0)
                                   : (64'(w_start_bin) > DEC_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_next <= 1'b0;
      r_mode_hex <= 1'b0;
      r_disp_hex <= 1'b0;
      r_hexval   <= '0;
      r_digits   <= '0;
      r_pend     <= 1'b0;
      r_pend_hex <= 1'b0;
      r_pend_bin <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (w_start) begin
        r_hexval   <= w_start_ext[BCD_W-1:0];
        r_mode_hex <= w_start_hex;
        r_ovf_next <= w_ovf_start;
      end
      if (w_commit) begin
        r_digits   <= r_mode_hex ? r_hexval : w_bcd;
        r_ovf      <= r_ovf_next;
        r_disp_hex <= r_mode_hex;
      end
      // Newest LOAD wins, even over a pending entry consumed this cycle
      if (LOAD && (r_state != IDLE)) begin
        r_pend     <= 1'b1;
        r_pend_bin <= BIN_IN;
        r_pend_hex <= HEX_MODE;
      end else if (w_start) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ref <= '0;
      r_idx <= '0;
    end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
      r_ref <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  always_comb begin
    w_digit = r_digits[4*int'(r_idx) +: 4];
    w_seg   = seg_decode(w_digit);
    if (r_ovf) begin
      w_seg = SEG_DASH;
    end
`ifdef LEADING_ZERO_BLANK_EN
    else if (!r_disp_hex && (r_idx != '0) &&
             ((r_digits >> (4*int'(r_idx))) == '0)) begin
      w_seg = SEG_BLANK;
    end
`else
    else begin
      w_seg = seg_decode(w_digit);
    end
`endif
    w_an = ~(DIGITS'(1) << r_idx);
  end

  assign BUSY = r_busy;
  assign OVF  = r_ovf;
  assign sseg = RST_N ? w_seg : SEG_BLANK;
  assign an   = RST_N ? w_an : '1;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Randomized and directed bench for sseg_scan_display against a value-level model.
module tb_sseg_scan_display;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 16;
  localparam int RDIV   = 3;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] BIN_IN = '0;
  logic        LOAD = 1'b0;
  logic        HEX_MODE = 1'b0;
  wire         BUSY, OVF;
  wire  [6:0]  sseg;
  wire  [3:0]  an;

  sseg_scan_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BIN_IN   (BIN_IN),
    .LOAD     (LOAD),
    .HEX_MODE (HEX_MODE),
    .BUSY     (BUSY),
    .OVF      (OVF),
    .sseg     (sseg),
    .an       (an)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  bit running = 1'b0;

  // Model: cycles left in the current job, job/pending/displayed values
  int          m_rem = 0;
  int          m_n = 0;
  int unsigned m_job_val = 0, m_pend_val = 0, m_disp_val = 0;
  bit          m_job_hex = 0, m_pend_hex = 0, m_pend = 0, m_disp_hex = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit m_ovf();
    return m_disp_hex ? ((m_disp_val >> 16) != 0) : (m_disp_val > 9999);
  endfunction

  function automatic logic [6:0] exp_seg(input int idx);
    int unsigned p, d;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (m_ovf()) return 7'b0111111;
    d = m_disp_hex ? ((m_disp_val >> (4*idx)) & 15) : ((m_disp_val / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (!m_disp_hex && idx > 0 && m_disp_val < p) return 7'h7F;
`endif
    return tbl[d];
  endfunction

  task automatic m_start(input int unsigned v, input bit h);
    m_job_val = v;
    m_job_hex = h;
    m_rem = h ? 1 : BIN_W + 1;
  endtask

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_rem = 0; m_n = 0; m_pend = 0; m_disp_val = 0; m_disp_hex = 0;
    end else begin
      m_n++;
      if (m_rem == 0) begin
        if (LOAD) begin
          m_start(BIN_IN, HEX_MODE);
          m_pend = 0;
        end else if (m_pend) begin
          m_start(m_pend_val, m_pend_hex);
          m_pend = 0;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp_val = m_job_val;
          m_disp_hex = m_job_hex;
          if (m_pend) begin
            m_start(m_pend_val, m_pend_hex);
            m_pend = 0;
          end
        end
        if (LOAD) begin
          m_pend = 1; m_pend_val = BIN_IN; m_pend_hex = HEX_MODE;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (running) begin
      int idx;
      idx = (m_n / RDIV) % DIGITS;
      if (!RST_N) begin
        chk("an_rst", an, 4'hF);
        chk("sseg_rst", sseg, 7'h7F);
      end else begin
        chk("an", an, 4'(~(4'd1 << idx)));
        chk("sseg", sseg, exp_seg(idx));
      end
      chk("busy", BUSY, (m_rem != 0));
      chk("ovf", OVF, m_ovf());
    end
  end

  task automatic ld(input int unsigned v, input bit h);
    BIN_IN = 16'(v); HEX_MODE = h; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (m_rem != 0 || m_pend); i++) @(negedge CLK);
    gap(1);
    chk("wait_idle", BUSY, 1'b0);
  endtask

  task automatic busy_len(input string nm, input int exp);
    int c;
    c = 0;
    for (int i = 0; i < 100 && BUSY; i++) begin
      c++;
      @(negedge CLK);
    end
    chk(nm, c, exp);
  endtask

  task automatic at_idx(input int k);
    for (int i = 0; i < 20 && ((m_n / RDIV) % DIGITS) != k; i++) @(negedge CLK);
  endtask

  initial begin
    logic [3:0] an_l [4];
    logic [6:0] sg_l [4];
    running = 1'b1;
    gap(3);
    RST_N = 1'b1;

    ld(1234, 0);
    busy_len("busy_len_dec", 17);
    an_l = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_l = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int k = 0; k < 4; k++) begin
      at_idx(k);
      chk("lit_1234_an", an, an_l[k]);
      chk("lit_1234_seg", sseg, sg_l[k]);
    end

    ld(9999, 0); wait_idle();
    at_idx(2); chk("lit_9999_seg", sseg, 7'b0010000); chk("lit_9999_ovf", OVF, 1'b0);
    ld(10000, 0); wait_idle();
    chk("lit_10000_ovf", OVF, 1'b1);
    at_idx(3); chk("lit_10000_dash", sseg, 7'b0111111);

    ld(16'hBEEF, 1);
    busy_len("busy_len_hex", 1);
    sg_l = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};
    for (int k = 0; k < 4; k++) begin
      at_idx(k);
      chk("lit_beef_seg", sseg, sg_l[k]);
    end

    ld(5, 0); gap(2); ld(42, 0); gap(2); ld(77, 0);
    wait_idle();
    at_idx(1); chk("lit_77_seg", sseg, 7'b1111000);

    ld(4321, 0); gap(7);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("lit_rst_an", an, 4'hF); chk("lit_rst_busy", BUSY, 1'b0);
    gap(1);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("lit_post_rst_an", an, 4'b1110); chk("lit_post_rst_seg", sseg, 7'b1000000);
    gap(20);
    chk("lit_pend_cleared", BUSY, 1'b0);

    ld(7, 0); wait_idle();
    at_idx(1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lit_7_d1", sseg, 7'h7F);
`else
    chk("lit_7_d1", sseg, 7'h40);
`endif
    at_idx(0); chk("lit_7_d0", sseg, 7'b1111000);

    for (int i = 0; i < 600; i++) begin
      LOAD = ($urandom_range(0, 5) == 0);
      BIN_IN = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12000)) : 16'($urandom);
      HEX_MODE = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
    end
    LOAD = 1'b0;
    wait_idle();
    gap(12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
